// File: rtl/jpeg_raster_buf_pkg.sv
// Shared state encodings, MCU sizes and parameter checks for the JPEG raster reorder buffer.
package jpeg_raster_buf_pkg;

    typedef enum logic [1:0] {
        JR_IDLE  = 2'd0,
        JR_FILL  = 2'd1,
        JR_DRAIN = 2'd2
    } jr_state_e;

    localparam int unsigned JR_MCU_8  = 8;
    localparam int unsigned JR_MCU_16 = 16;

    // Position tags that travel with each pixel through the read pipeline and skid buffer.
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        eol;
        logic        eof;
    } jr_meta_t;

    function automatic bit jr_max_width_ok(input int unsigned w);
        return (w != 0) && ((w % JR_MCU_16) == 0);
    endfunction

endpackage

// File: rtl/jpeg_raster_buf_if.sv
// Pixel stream interface: MCU-order input handshake and raster-order output handshake.
interface jpeg_raster_buf_if #(
    parameter int unsigned PIX_W    = 8,
    parameter int unsigned CHANNELS = 3
);
    localparam int unsigned DW = PIX_W * CHANNELS;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_pix;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_pix;
    logic [15:0]   out_x;
    logic [15:0]   out_y;
    logic          out_eol;
    logic          out_eof;

    // Upstream producer and downstream sink side.
    modport master (
        output in_valid, in_pix, out_ready,
        input  in_ready, out_valid, out_pix, out_x, out_y, out_eol, out_eof
    );

    // Raster buffer side.
    modport slave (
        input  in_valid, in_pix, out_ready,
        output in_ready, out_valid, out_pix, out_x, out_y, out_eol, out_eof
    );

endinterface

// File: rtl/jpeg_raster_ram.sv
// Simple dual-port synchronous RAM with one-cycle read latency; swap for a vendor macro here.
module jpeg_raster_ram #(
    parameter int unsigned DW    = 24,
    parameter int unsigned DEPTH = 16384,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/jpeg_raster_buf.sv
// Reorders MCU-ordered decoded pixels into cropped full-image raster order.
// Define JPEG_RASTER_PINGPONG_EN for two strip banks so filling overlaps draining.
module jpeg_raster_buf
    import jpeg_raster_buf_pkg::*;
#(
    parameter int unsigned MAX_WIDTH = 1024,
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned CHANNELS  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [15:0]        width,
    input  logic [15:0]        heigth,
    input  logic               pic_is_411,
    jpeg_raster_buf_if.slave   bus,
    output logic               busy,
    output logic               cfg_err
);

`ifdef JPEG_RASTER_PINGPONG_EN
    localparam int unsigned NBANKS = 2;
`else
    localparam int unsigned NBANKS = 1;
`endif
    localparam int unsigned DW         = PIX_W * CHANNELS;
    localparam int unsigned BANK_WORDS = JR_MCU_16 * MAX_WIDTH;
    localparam int unsigned DEPTH      = NBANKS * BANK_WORDS;
    localparam int unsigned AW         = $clog2(DEPTH);

    if (!jr_max_width_ok(MAX_WIDTH)) begin : g_bad_max_width
        $error("jpeg_raster_buf: MAX_WIDTH must be a non-zero multiple of 16");
    end

    jr_state_e   state_q;
    logic        busy_q, cfg_err_q;
    logic        s16_q;
    logic [15:0] width_q, heigth_q, mcus_q, strips_q;

    // Fill side: MCU-order write counters.
    logic        fill_on_q;
    logic [7:0]  idx_q;
    logic [15:0] mcu_x_q, fill_strip_q;
    logic        wr_bank_q;
    logic [1:0]  full_q;

    // Drain side: raster-order read counters.
    logic        rd_bank_q;
    logic [15:0] rd_x_q, rd_y_q, y_base_q, drain_strip_q;

    logic        rd_pend_q;
    jr_meta_t    rd_meta_q;
    logic [1:0]  cnt_q;
    logic [DW-1:0] pix0_q, pix1_q;
    jr_meta_t    meta0_q, meta1_q;

    logic [15:0] s_size, rows_rem, rows_valid;
    logic        cfg_bad, start_ok;
    logic [15:0] mcus_new, strips_new;
    logic        in_ready, wr_fire, idx_last, mcu_last, fill_done, bank_ready;
    logic [3:0]  wr_row;
    logic [15:0] wr_col;
    logic [AW-1:0] wr_addr, rd_addr;
    logic        pop, issue, rd_last_x, rd_last_y, last_strip;
    logic [2:0]  occ;
    jr_meta_t    meta_new;
    logic [DW-1:0] ram_rdata;

    assign s_size   = s16_q ? 16'(JR_MCU_16) : 16'(JR_MCU_8);
    assign cfg_bad  = (width == 16'd0) || (heigth == 16'd0) || (32'(width) > MAX_WIDTH);
    assign start_ok = start && !busy_q;

    assign mcus_new   = pic_is_411 ? 16'(({1'b0, width} + 17'd15) >> 4)
                                   : 16'(({1'b0, width} + 17'd7) >> 3);
    assign strips_new = pic_is_411 ? 16'(({1'b0, heigth} + 17'd15) >> 4)
                                   : 16'(({1'b0, heigth} + 17'd7) >> 3);

    assign in_ready  = fill_on_q && !full_q[wr_bank_q];
    assign wr_fire   = bus.in_valid && in_ready;
    assign idx_last  = idx_q == (s16_q ? 8'd255 : 8'd63);
    assign mcu_last  = mcu_x_q == (mcus_q - 16'd1);
    assign fill_done = wr_fire && idx_last && mcu_last;

    assign wr_row  = s16_q ? idx_q[7:4] : {1'b0, idx_q[5:3]};
    assign wr_col  = s16_q ? {mcu_x_q[11:0], idx_q[3:0]} : {mcu_x_q[12:0], idx_q[2:0]};
    assign wr_addr = AW'(32'(wr_bank_q) * BANK_WORDS + 32'(wr_row) * MAX_WIDTH + 32'(wr_col));

    // A bank completing this cycle counts as ready so draining starts without a bubble.
    assign bank_ready = full_q[rd_bank_q] || (fill_done && (wr_bank_q == rd_bank_q));

    assign rows_rem   = heigth_q - y_base_q;
    assign rows_valid = (rows_rem < s_size) ? rows_rem : s_size;

    assign pop = bus.out_valid && bus.out_ready;
    // Occupancy after this cycle's pop, counting the read already in flight.
    assign occ   = {1'b0, cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    assign issue = (state_q == JR_DRAIN) && (occ < 3'd2);

    assign rd_last_x  = rd_x_q == (width_q - 16'd1);
    assign rd_last_y  = rd_y_q == (rows_valid - 16'd1);
    assign last_strip = drain_strip_q == (strips_q - 16'd1);
    assign rd_addr    = AW'(32'(rd_bank_q) * BANK_WORDS + 32'(rd_y_q) * MAX_WIDTH + 32'(rd_x_q));

    always_comb begin
        meta_new     = '0;
        meta_new.x   = rd_x_q;
        meta_new.y   = y_base_q + rd_y_q;
        meta_new.eol = rd_last_x;
        meta_new.eof = rd_last_x && rd_last_y && last_strip;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= JR_IDLE;
            busy_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
            s16_q         <= 1'b0;
            width_q       <= '0;
            heigth_q      <= '0;
            mcus_q        <= '0;
            strips_q      <= '0;
            fill_on_q     <= 1'b0;
            idx_q         <= '0;
            mcu_x_q       <= '0;
            fill_strip_q  <= '0;
            wr_bank_q     <= 1'b0;
            full_q        <= '0;
            rd_bank_q     <= 1'b0;
            rd_x_q        <= '0;
            rd_y_q        <= '0;
            y_base_q      <= '0;
            drain_strip_q <= '0;
        end else begin
            if (start_ok) begin
                if (cfg_bad) begin
                    cfg_err_q <= 1'b1;
                end else begin
                    cfg_err_q     <= 1'b0;
                    busy_q        <= 1'b1;
                    s16_q         <= pic_is_411;
                    width_q       <= width;
                    heigth_q      <= heigth;
                    mcus_q        <= mcus_new;
                    strips_q      <= strips_new;
                    fill_on_q     <= 1'b1;
                    idx_q         <= '0;
                    mcu_x_q       <= '0;
                    fill_strip_q  <= '0;
                    wr_bank_q     <= 1'b0;
                    full_q        <= '0;
                    rd_bank_q     <= 1'b0;
                    rd_x_q        <= '0;
                    rd_y_q        <= '0;
                    y_base_q      <= '0;
                    drain_strip_q <= '0;
                    state_q       <= JR_FILL;
                end
            end

            if (wr_fire) begin
                if (idx_last) begin
                    idx_q <= '0;
                    if (mcu_last) begin
                        mcu_x_q           <= '0;
                        full_q[wr_bank_q] <= 1'b1;
                        wr_bank_q         <= (NBANKS == 2) ? !wr_bank_q : 1'b0;
                        fill_strip_q      <= fill_strip_q + 16'd1;
                        if (fill_strip_q == strips_q - 16'd1) begin
                            fill_on_q <= 1'b0;
                        end
                    end else begin
                        mcu_x_q <= mcu_x_q + 16'd1;
                    end
                end else begin
                    idx_q <= idx_q + 8'd1;
                end
            end

            case (state_q)
                JR_IDLE: ;
                JR_FILL: begin
                    if (bank_ready) begin
                        state_q <= JR_DRAIN;
                    end
                end
                JR_DRAIN: begin
                    if (issue) begin
                        if (rd_last_x) begin
                            rd_x_q <= '0;
                            if (rd_last_y) begin
                                rd_y_q            <= '0;
                                full_q[rd_bank_q] <= 1'b0;
                                rd_bank_q         <= (NBANKS == 2) ? !rd_bank_q : 1'b0;
                                if (last_strip) begin
                                    state_q <= JR_IDLE;
                                end else begin
                                    state_q       <= JR_FILL;
                                    drain_strip_q <= drain_strip_q + 16'd1;
                                    y_base_q      <= y_base_q + s_size;
                                end
                            end else begin
                                rd_y_q <= rd_y_q + 16'd1;
                            end
                        end else begin
                            rd_x_q <= rd_x_q + 16'd1;
                        end
                    end
                end
                default: state_q <= JR_IDLE;
            endcase

            // busy holds until the final pixel actually leaves, not merely when its read issues.
            if (pop && meta0_q.eof) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Read pipeline stage and 2-entry skid buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            rd_meta_q <= '0;
            cnt_q     <= '0;
            pix0_q    <= '0;
            pix1_q    <= '0;
            meta0_q   <= '0;
            meta1_q   <= '0;
        end else begin
            rd_pend_q <= issue;
            if (issue) begin
                rd_meta_q <= meta_new;
            end
            case (cnt_q)
                2'd0: begin
                    if (rd_pend_q) begin
                        pix0_q  <= ram_rdata;
                        meta0_q <= rd_meta_q;
                        cnt_q   <= 2'd1;
                    end
                end
                2'd1: begin
                    if (rd_pend_q && pop) begin
                        pix0_q  <= ram_rdata;
                        meta0_q <= rd_meta_q;
                    end else if (rd_pend_q) begin
                        pix1_q  <= ram_rdata;
                        meta1_q <= rd_meta_q;
                        cnt_q   <= 2'd2;
                    end else if (pop) begin
                        cnt_q <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        pix0_q  <= pix1_q;
                        meta0_q <= meta1_q;
                        if (rd_pend_q) begin
                            pix1_q  <= ram_rdata;
                            meta1_q <= rd_meta_q;
                        end else begin
                            cnt_q <= 2'd1;
                        end
                    end
                end
                default: cnt_q <= 2'd0;
            endcase
        end
    end

    jpeg_raster_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_addr),
        .wdata (bus.in_pix),
        .re    (issue),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = cnt_q != 2'd0;
    assign bus.out_pix   = pix0_q;
    assign bus.out_x     = meta0_q.x;
    assign bus.out_y     = meta0_q.y;
    assign bus.out_eol   = meta0_q.eol;
    assign bus.out_eof   = meta0_q.eof;
    assign busy          = busy_q;
    assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_jpeg_raster_buf.sv
// Directed bench for jpeg_raster_buf: reorder, crop, back-pressure, config errors and reset.
module tb_jpeg_raster_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] width, heigth;
    logic        pic_is_411;
    logic        busy, cfg_err;
    logic        rand_mode = 1'b0;

    int errors = 0;
    int checks = 0;

    jpeg_raster_buf_if #(.PIX_W(8), .CHANNELS(3)) bus ();

    jpeg_raster_buf #(
        .MAX_WIDTH (1024),
        .PIX_W     (8),
        .CHANNELS  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .width      (width),
        .heigth     (heigth),
        .pic_is_411 (pic_is_411),
        .bus        (bus),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        bus.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: records accepted pixels and counts fields changing under a stall.
    logic [23:0] qpix[$];
    logic [15:0] qx[$], qy[$];
    logic        qeol[$], qeof[$];
    logic        stall_q = 1'b0;
    logic [23:0] spix;
    logic [15:0] sx, sy;
    logic        seol, seof;
    int          stab_err = 0;
    int          stall_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q && !(bus.out_valid === 1'b1 && bus.out_pix === spix && bus.out_x === sx
                    && bus.out_y === sy && bus.out_eol === seol && bus.out_eof === seof)) begin
                stab_err++;
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                qpix.push_back(bus.out_pix);
                qx.push_back(bus.out_x);
                qy.push_back(bus.out_y);
                qeol.push_back(bus.out_eol);
                qeof.push_back(bus.out_eof);
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
                stall_cnt++;
            end
            stall_q <= (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
            spix    <= bus.out_pix;
            sx      <= bus.out_x;
            sy      <= bus.out_y;
            seol    <= bus.out_eol;
            seof    <= bus.out_eof;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_pic(input int w, input int h, input bit s411);
        @(negedge clk);
        start      = 1'b1;
        width      = 16'(w);
        heigth     = 16'(h);
        pic_is_411 = s411;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers n pixels valued base..base+n-1, one per cycle when in_ready allows.
    task automatic send(input string tag, input int n, input int base);
        int tmo = 0;
        for (int k = 0; k < n; k++) begin
            int w = 0;
            bus.in_valid = 1'b1;
            bus.in_pix   = 24'(base + k);
            while (bus.in_ready !== 1'b1 && w < 3000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 3000) begin
                tmo = 1;
                break;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check({tag, "_send_timeout"}, 32'(tmo), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (busy !== 1'b0 && c < 20000) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Expected value for (x,y): inputs were numbered in MCU order starting at 0.
    task automatic verify(input string tag, input int base, input int w, input int h,
                          input int s, input int mcus);
        int n   = w * h;
        int got = qpix.size() - base;
        int bad = 0;
        check({tag, "_count"}, 32'(got), 32'(n));
        for (int k = 0; k < n && k < got; k++) begin
            int x = k % w;
            int y = k / w;
            int e = (y / s) * (mcus * s * s) + (x / s) * s * s + (y % s) * s + (x % s);
            if (qpix[base + k] !== 24'(e) || qx[base + k] !== 16'(x) || qy[base + k] !== 16'(y)
                    || qeol[base + k] !== (x == w - 1) || qeof[base + k] !== (k == n - 1)) begin
                bad++;
            end
        end
        check({tag, "_content"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int b1, b2, b3a, b3b, b5, s0, st0, maxx, maxy, diff;
        rst          = 1'b1;
        start        = 1'b0;
        width        = '0;
        heigth       = '0;
        pic_is_411   = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_pix   = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_pix", 32'(bus.out_pix), 32'd0);
        check("rst_out_eof", 32'(bus.out_eof), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        rst = 1'b0;

        // 16x8, 8x8 MCUs, full-rate sink; a second start while busy must be ignored.
        b1 = qpix.size();
        start_pic(16, 8, 1'b0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_in_ready", 32'(bus.in_ready), 32'd1);
        start_pic(8, 8, 1'b1);
        send("t1", 128, 0);
        check("t1_lat0", 32'(bus.out_valid), 32'd0);
        check("t1_in_ready_drain", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("t1_lat1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("t1_lat2", 32'(bus.out_valid), 32'd1);
        wait_idle("t1");
        verify("t1", b1, 16, 8, 8, 2);
        check("t1_in_ready_end", 32'(bus.in_ready), 32'd0);

        // 20x18 with 16x16 MCUs: right and bottom padding cropped.
        b2 = qpix.size();
        start_pic(20, 18, 1'b1);
        send("t2", 1024, 0);
        wait_idle("t2");
        verify("t2", b2, 20, 18, 16, 2);
        maxx = 0;
        maxy = 0;
        for (int k = b2; k < qpix.size(); k++) begin
            if (int'(qx[k]) > maxx) maxx = int'(qx[k]);
            if (int'(qy[k]) > maxy) maxy = int'(qy[k]);
        end
        check("t2_max_x", 32'(maxx), 32'd19);
        check("t2_max_y", 32'(maxy), 32'd17);

        // 64x32 at full rate, then again with a 50% random sink.
        b3a = qpix.size();
        start_pic(64, 32, 1'b0);
        send("t3a", 2048, 0);
        wait_idle("t3a");
        verify("t3a", b3a, 64, 32, 8, 8);
        b3b = qpix.size();
        s0  = stab_err;
        st0 = stall_cnt;
        rand_mode = 1'b1;
        start_pic(64, 32, 1'b0);
        send("t3b", 2048, 0);
        wait_idle("t3b");
        rand_mode = 1'b0;
        verify("t3b", b3b, 64, 32, 8, 8);
        diff = 0;
        for (int k = 0; k < 2048 && b3b + k < qpix.size(); k++) begin
            if (qpix[b3a + k] !== qpix[b3b + k] || qx[b3a + k] !== qx[b3b + k]
                    || qy[b3a + k] !== qy[b3b + k]) begin
                diff++;
            end
        end
        check("t3_runs_equal", 32'(diff), 32'd0);
        check("t3_stable_stall", 32'(stab_err - s0), 32'd0);
        check("t3_stalls_seen", 32'(stall_cnt - st0 > 0), 32'd1);

        // Configuration errors.
        start_pic(1040, 8, 1'b0);
        check("t4_cfg_err", 32'(cfg_err), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_in_ready", 32'(bus.in_ready), 32'd0);
        start_pic(16, 0, 1'b0);
        check("t4_h0_cfg_err", 32'(cfg_err), 32'd1);
        check("t4_h0_busy", 32'(busy), 32'd0);
        start_pic(1024, 8, 1'b0);
        check("t4_clear_cfg_err", 32'(cfg_err), 32'd0);
        check("t4_ok_busy", 32'(busy), 32'd1);

        // Reset in the drain of strip 0, then a fresh picture.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_pic(16, 16, 1'b0);
        send("t5a", 128, 0);
        repeat (4) @(negedge clk);
        check("t5_draining", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        b5 = qpix.size();
        start_pic(16, 8, 1'b0);
        send("t5b", 128, 0);
        wait_idle("t5b");
        verify("t5b", b5, 16, 8, 8, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
